mem_wb_stage: RTL and testbench

Memory/write-back stage of the 5-stage CPU, directly downstream of the execute stage. It consumes the execute stage's registered outputs and the data-SRAM read word. It aligns and extends load data (LB/LBU/LH/LHU/LW/LWL/LWR), owns the architectural HI/LO registers, and presents one registered register-file write port plus a combinational forwarding port for the hazard unit.

---
 rtl/cpu_defs.sv | 33 +++
 rtl/mem_wb_stage_load_align.sv | 66 ++++++
 rtl/mem_wb_stage.sv | 94 +++++++++
 tb/tb_mem_wb_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Encodings shared by the execute and memory/write-back stages, plus small
// extension helpers used by load alignment.
package cpu_defs;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4,
        LD_LWL = 3'd5,
        LD_LWR = 3'd6
    } load_type_e;

    typedef enum logic [2:0] {
        ST_SW  = 3'd0,
        ST_SB  = 3'd1,
        ST_SH  = 3'd2,
        ST_SWL = 3'd3,
        ST_SWR = 3'd4
    } store_type_e;

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load-data aligner: picks and extends byte/half lanes and
// merges partial words for LWL/LWR.
module load_align
    import cpu_defs::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] aligned
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_word;
    logic [31:0] lwr_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[offset];
    // Odd halfword offsets never reach here; execute raises AdEL for them.
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        lwl_word = rdata;
        lwr_word = rdata;
        case (offset)
            2'd0: begin
                lwl_word = {rdata[7:0],  rt[23:0]};
                lwr_word = rdata;
            end
            2'd1: begin
                lwl_word = {rdata[15:0], rt[15:0]};
                lwr_word = {rt[31:24], rdata[31:8]};
            end
            2'd2: begin
                lwl_word = {rdata[23:0], rt[7:0]};
                lwr_word = {rt[31:16], rdata[31:16]};
            end
            default: begin
                lwl_word = rdata;
                lwr_word = {rt[31:8], rdata[31:24]};
            end
        endcase
    end

    always_comb begin
        aligned = rdata;
        case (load_type)
            LD_LB:   aligned = ext8(byte_sel, 1'b1);
            LD_LBU:  aligned = ext8(byte_sel, 1'b0);
            LD_LH:   aligned = ext16(half_sel, 1'b1);
            LD_LHU:  aligned = ext16(half_sel, 1'b0);
            LD_LWL:  aligned = lwl_word;
            LD_LWR:  aligned = lwr_word;
            default: aligned = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: load alignment, HI/LO ownership, forwarding port
// and the registered register-file write port.
module mem_wb_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_HILO = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_reg_en,
    input  logic        exe_mem_read,
    input  logic [4:0]  exe_reg_waddr,
    input  logic [31:0] alu_result_reg,
    input  logic [2:0]  exe_load_type,
    input  logic [31:0] exe_load_rt_data,
    input  logic [31:0] data_sram_rdata,
    input  logic        exe_hi_rd,
    input  logic        exe_lo_rd,
    input  logic        exe_hi_wr,
    input  logic        exe_lo_wr,
    input  logic        exe_MD_complete,
    input  logic [63:0] exe_MD_result,
    output logic        mem_fwd_en,
    output logic [4:0]  mem_fwd_waddr,
    output logic [31:0] mem_fwd_wdata,
    output logic        wb_reg_wen,
    output logic [4:0]  wb_reg_waddr,
    output logic [31:0] wb_reg_wdata,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    logic [31:0] load_word;
    logic [31:0] hi_d;
    logic [31:0] lo_d;
    logic [31:0] result;
    logic        wb_reg_wen_d;
    logic [4:0]  wb_reg_waddr_d;
    logic [31:0] wb_reg_wdata_d;
    logic        wb_reg_wen_q;
    logic [4:0]  wb_reg_waddr_q;
    logic [31:0] wb_reg_wdata_q;

    load_align u_load_align (
        .load_type (exe_load_type),
        .offset    (alu_result_reg[1:0]),
        .rdata     (data_sram_rdata),
        .rt        (exe_load_rt_data),
        .aligned   (load_word)
    );

    always_comb begin
        // A move is younger than an in-flight MD op, so it wins.
        hi_d = hi_q;
        lo_d = lo_q;
        if (exe_hi_wr)            hi_d = alu_result_reg;
        else if (exe_MD_complete) hi_d = exe_MD_result[63:32];
        if (exe_lo_wr)            lo_d = alu_result_reg;
        else if (exe_MD_complete) lo_d = exe_MD_result[31:0];

        result = alu_result_reg;
        if (exe_hi_rd)         result = hi_d;
        else if (exe_lo_rd)    result = lo_d;
        else if (exe_mem_read) result = load_word;

        wb_reg_wen_d   = exe_reg_en;
        wb_reg_waddr_d = exe_reg_waddr;
        wb_reg_wdata_d = result;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q           <= RESET_HILO;
            lo_q           <= RESET_HILO;
            wb_reg_wen_q   <= 1'b0;
            wb_reg_waddr_q <= 5'd0;
            wb_reg_wdata_q <= 32'd0;
        end else begin
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            wb_reg_wen_q   <= wb_reg_wen_d;
            wb_reg_waddr_q <= wb_reg_waddr_d;
            wb_reg_wdata_q <= wb_reg_wdata_d;
        end
    end

    assign mem_fwd_en    = exe_reg_en;
    assign mem_fwd_waddr = exe_reg_waddr;
    assign mem_fwd_wdata = result;
    assign wb_reg_wen    = wb_reg_wen_q;
    assign wb_reg_waddr  = wb_reg_waddr_q;
    assign wb_reg_wdata  = wb_reg_wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: loads, LWL/LWR merges, HI/LO bypass and
// priority, reset behaviour and back-to-back write-back.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exe_reg_en;
    logic        exe_mem_read;
    logic [4:0]  exe_reg_waddr;
    logic [31:0] alu_result_reg;
    logic [2:0]  exe_load_type;
    logic [31:0] exe_load_rt_data;
    logic [31:0] data_sram_rdata;
    logic        exe_hi_rd, exe_lo_rd, exe_hi_wr, exe_lo_wr;
    logic        exe_MD_complete;
    logic [63:0] exe_MD_result;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_waddr;
    logic [31:0] mem_fwd_wdata;
    logic        wb_reg_wen;
    logic [4:0]  wb_reg_waddr;
    logic [31:0] wb_reg_wdata;
    logic [31:0] hi_q, lo_q;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .exe_reg_en       (exe_reg_en),
        .exe_mem_read     (exe_mem_read),
        .exe_reg_waddr    (exe_reg_waddr),
        .alu_result_reg   (alu_result_reg),
        .exe_load_type    (exe_load_type),
        .exe_load_rt_data (exe_load_rt_data),
        .data_sram_rdata  (data_sram_rdata),
        .exe_hi_rd        (exe_hi_rd),
        .exe_lo_rd        (exe_lo_rd),
        .exe_hi_wr        (exe_hi_wr),
        .exe_lo_wr        (exe_lo_wr),
        .exe_MD_complete  (exe_MD_complete),
        .exe_MD_result    (exe_MD_result),
        .mem_fwd_en       (mem_fwd_en),
        .mem_fwd_waddr    (mem_fwd_waddr),
        .mem_fwd_wdata    (mem_fwd_wdata),
        .wb_reg_wen       (wb_reg_wen),
        .wb_reg_waddr     (wb_reg_waddr),
        .wb_reg_wdata     (wb_reg_wdata),
        .hi_q             (hi_q),
        .lo_q             (lo_q)
    );

    task automatic set_idle();
        exe_reg_en       = 1'b0;
        exe_mem_read     = 1'b0;
        exe_reg_waddr    = 5'd0;
        alu_result_reg   = 32'd0;
        exe_load_type    = 3'd0;
        exe_load_rt_data = 32'd0;
        data_sram_rdata  = 32'd0;
        exe_hi_rd        = 1'b0;
        exe_lo_rd        = 1'b0;
        exe_hi_wr        = 1'b0;
        exe_lo_wr        = 1'b0;
        exe_MD_complete  = 1'b0;
        exe_MD_result    = 64'd0;
    endtask

    task automatic drive_load(input logic [2:0] t, input logic [31:0] addr,
                              input logic [31:0] rd, input logic [31:0] rt,
                              input logic [4:0] wa);
        @(negedge clk);
        set_idle();
        exe_reg_en       = 1'b1;
        exe_mem_read     = 1'b1;
        exe_reg_waddr    = wa;
        alu_result_reg   = addr;
        exe_load_type    = t;
        data_sram_rdata  = rd;
        exe_load_rt_data = rt;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (wb_reg_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %h want 0", wb_reg_wen); end
        n_vec++; if (wb_reg_waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr got %h want 0", wb_reg_waddr); end
        n_vec++; if (wb_reg_wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata got %h want 0", wb_reg_wdata); end
        n_vec++; if (hi_q !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi_q); end
        n_vec++; if (lo_q !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo_q); end
        @(negedge clk);
        resetn = 1'b1;
        $display("reset: wen=%b waddr=%0d wdata=%h hi=%h lo=%h", wb_reg_wen, wb_reg_waddr, wb_reg_wdata, hi_q, lo_q);
    endtask

    task automatic test_byte_half();
        logic [2:0]  t_tab [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
        logic [31:0] a_tab [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100, 32'h100};
        logic [31:0] e_tab [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                   32'h0000_1234, 32'h80FF_1234, 32'h80FF_1234};
        for (int i = 0; i < 6; i++) begin
            drive_load(t_tab[i], a_tab[i], 32'h80FF_1234, 32'hDEAD_BEEF, 5'd5);
            n_vec++; if (mem_fwd_wdata !== e_tab[i]) begin n_err++; $display("FAIL load%0d_fwd got %h want %h", i, mem_fwd_wdata, e_tab[i]); end
            n_vec++; if (mem_fwd_en !== 1'b1 || mem_fwd_waddr !== 5'd5) begin n_err++; $display("FAIL load%0d_fwd_ctl got %b/%0d want 1/5", i, mem_fwd_en, mem_fwd_waddr); end
            @(posedge clk); #1;
            n_vec++; if (wb_reg_wdata !== e_tab[i] || wb_reg_wen !== 1'b1 || wb_reg_waddr !== 5'd5) begin
                n_err++; $display("FAIL load%0d_wb got %b/%0d/%h want 1/5/%h", i, wb_reg_wen, wb_reg_waddr, wb_reg_wdata, e_tab[i]);
            end
            $display("load type=%0d addr=%h fwd=%h wb=%h", t_tab[i], a_tab[i], mem_fwd_wdata, wb_reg_wdata);
        end
    endtask

    task automatic test_lwl_lwr();
        logic [31:0] lwl_tab [4] = '{32'hDD22_3344, 32'hCCDD_3344, 32'hBBCC_DD44, 32'hAABB_CCDD};
        logic [31:0] lwr_tab [4] = '{32'hAABB_CCDD, 32'h11AA_BBCC, 32'h1122_AABB, 32'h1122_33AA};
        for (int i = 0; i < 4; i++) begin
            drive_load(3'd5, 32'h200 + i, 32'hAABB_CCDD, 32'h1122_3344, 5'd8);
            n_vec++; if (mem_fwd_wdata !== lwl_tab[i]) begin n_err++; $display("FAIL lwl%0d got %h want %h", i, mem_fwd_wdata, lwl_tab[i]); end
            $display("lwl off=%0d fwd=%h", i, mem_fwd_wdata);
            drive_load(3'd6, 32'h200 + i, 32'hAABB_CCDD, 32'h1122_3344, 5'd8);
            n_vec++; if (mem_fwd_wdata !== lwr_tab[i]) begin n_err++; $display("FAIL lwr%0d got %h want %h", i, mem_fwd_wdata, lwr_tab[i]); end
            $display("lwr off=%0d fwd=%h", i, mem_fwd_wdata);
        end
    endtask

    task automatic test_md_bypass();
        @(negedge clk);
        set_idle();
        exe_reg_en      = 1'b1;
        exe_reg_waddr   = 5'd2;
        exe_hi_rd       = 1'b1;
        exe_MD_complete = 1'b1;
        exe_MD_result   = 64'h0000_0001_0000_0002;
        alu_result_reg  = 32'h0000_0ABC;
        #1;
        n_vec++; if (mem_fwd_wdata !== 32'd1) begin n_err++; $display("FAIL mfhi_bypass got %h want 1", mem_fwd_wdata); end
        exe_hi_rd = 1'b0;
        exe_lo_rd = 1'b1;
        #1;
        n_vec++; if (mem_fwd_wdata !== 32'd2) begin n_err++; $display("FAIL mflo_bypass got %h want 2", mem_fwd_wdata); end
        @(posedge clk); #1;
        n_vec++; if (hi_q !== 32'd1 || lo_q !== 32'd2) begin n_err++; $display("FAIL md_update got %h/%h want 1/2", hi_q, lo_q); end
        n_vec++; if (wb_reg_wdata !== 32'd2) begin n_err++; $display("FAIL mflo_wb got %h want 2", wb_reg_wdata); end
        $display("md: hi=%h lo=%h wb=%h", hi_q, lo_q, wb_reg_wdata);
        // HI/LO must hold when nothing writes them.
        @(negedge clk);
        set_idle();
        alu_result_reg = 32'h1234;
        @(posedge clk); #1;
        n_vec++; if (hi_q !== 32'd1 || lo_q !== 32'd2) begin n_err++; $display("FAIL hilo_hold got %h/%h want 1/2", hi_q, lo_q); end
        $display("hold: hi=%h lo=%h", hi_q, lo_q);
    endtask

    task automatic test_move_vs_md();
        @(negedge clk);
        set_idle();
        exe_hi_wr       = 1'b1;
        alu_result_reg  = 32'h5;
        exe_MD_complete = 1'b1;
        exe_MD_result   = 64'h0000_0009_0000_0077;
        @(posedge clk); #1;
        n_vec++; if (hi_q !== 32'h5) begin n_err++; $display("FAIL move_beats_md_hi got %h want 5", hi_q); end
        n_vec++; if (lo_q !== 32'h77) begin n_err++; $display("FAIL move_md_lo got %h want 77", lo_q); end
        $display("move/md: hi=%h lo=%h", hi_q, lo_q);
        @(negedge clk);
        set_idle();
        exe_lo_wr      = 1'b1;
        exe_lo_rd      = 1'b1;
        exe_mem_read   = 1'b1;
        alu_result_reg = 32'hCAFE_0001;
        #1;
        n_vec++; if (mem_fwd_wdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL mflo_move_bypass got %h want cafe0001", mem_fwd_wdata); end
        @(posedge clk); #1;
        n_vec++; if (lo_q !== 32'hCAFE_0001 || hi_q !== 32'h5) begin n_err++; $display("FAIL mtlo got %h/%h want 5/cafe0001", hi_q, lo_q); end
        $display("mtlo: hi=%h lo=%h", hi_q, lo_q);
    endtask

    task automatic test_reset_pulse();
        @(negedge clk);
        set_idle();
        resetn          = 1'b0;
        exe_reg_en      = 1'b1;
        exe_reg_waddr   = 5'd9;
        alu_result_reg  = 32'h44;
        exe_MD_complete = 1'b1;
        exe_MD_result   = 64'h0000_0003_0000_0004;
        @(posedge clk); #1;
        n_vec++; if (wb_reg_wen !== 1'b0 || wb_reg_wdata !== 32'd0) begin n_err++; $display("FAIL pulse_wb got %b/%h want 0/0", wb_reg_wen, wb_reg_wdata); end
        n_vec++; if (hi_q !== 32'd0 || lo_q !== 32'd0) begin n_err++; $display("FAIL pulse_hilo got %h/%h want 0/0", hi_q, lo_q); end
        $display("reset pulse: wen=%b hi=%h lo=%h", wb_reg_wen, hi_q, lo_q);
        @(negedge clk);
        set_idle();
        resetn = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_idle();
        exe_reg_en     = 1'b1;
        exe_reg_waddr  = 5'd3;
        alu_result_reg = 32'd7;
        @(posedge clk); #1;
        n_vec++; if (wb_reg_wen !== 1'b1 || wb_reg_waddr !== 5'd3 || wb_reg_wdata !== 32'd7) begin
            n_err++; $display("FAIL b2b_first got %b/%0d/%h want 1/3/7", wb_reg_wen, wb_reg_waddr, wb_reg_wdata);
        end
        $display("b2b: r%0d=%h", wb_reg_waddr, wb_reg_wdata);
        @(negedge clk);
        exe_reg_waddr  = 5'd4;
        alu_result_reg = 32'd9;
        @(posedge clk); #1;
        n_vec++; if (wb_reg_wen !== 1'b1 || wb_reg_waddr !== 5'd4 || wb_reg_wdata !== 32'd9) begin
            n_err++; $display("FAIL b2b_second got %b/%0d/%h want 1/4/9", wb_reg_wen, wb_reg_waddr, wb_reg_wdata);
        end
        $display("b2b: r%0d=%h", wb_reg_waddr, wb_reg_wdata);
        @(negedge clk);
        set_idle();
        @(posedge clk); #1;
        n_vec++; if (wb_reg_wen !== 1'b0) begin n_err++; $display("FAIL idle_wen got %b want 0", wb_reg_wen); end
        $display("idle: wen=%b", wb_reg_wen);
    endtask

    initial begin
        test_reset();
        test_byte_half();
        test_lwl_lwr();
        test_md_bypass();
        test_move_vs_md();
        test_reset_pulse();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
